multicycle_sequencer: RTL and testbench

MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

---
 rtl/multicycle_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer.sv
// Control sequencer for a multicycle CPU: steps each instruction through fetch,
// decode, execute, memory and write-back, with error halts, stop and counters.
module multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             reg_write,
  input  logic             branch,
  input  logic             inv_addr,
  input  logic             inv_op,
  input  logic             inv_func,
  input  logic             inv_reg_addr,
  input  logic             inv_mem_addr,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write_en,
  output logic [2:0]       state,
  output logic             halted,
  output logic [2:0]       err_code,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instret
);

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_MEM     = 3'd4,
    S_WB      = 3'd5,
    S_HALT    = 3'd6
  } state_t;

  state_t            state_q, state_d;
  state_t            retire_state;
  logic [2:0]        err_q, err_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              stop_pend_q, stop_pend_d;
  logic [CNT_W-1:0]  cycle_q, instret_q;
  logic              exec_retire;
  logic              active;

  // Branches and no-ops both simply retire from EXECUTE.
  assign exec_retire  = branch | ~(mem_read | mem_write | reg_write);
  assign retire_state = (stop || stop_pend_q) ? S_IDLE : S_FETCH;
  assign active       = (state_q != S_IDLE) && (state_q != S_HALT);

  always_comb begin
    state_d      = state_q;
    err_d        = err_q;
    wait_d       = wait_q;
    stop_pend_d  = stop_pend_q | stop;
    imem_req     = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    reg_write_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          wait_d  = '0;
        end
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          if (inv_addr) begin
            state_d = S_HALT;
            err_d   = 3'd1;
          end else begin
            ir_write = 1'b1;
            state_d  = S_DECODE;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_HALT;
          err_d   = 3'd4;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        if (inv_op || inv_func || inv_reg_addr) begin
          state_d = S_HALT;
          err_d   = 3'd2;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        if (mem_read || mem_write) begin
          state_d = S_MEM;
          wait_d  = '0;
        end else if (reg_write) begin
          state_d = S_WB;
        end else if (exec_retire) begin
          pc_write    = 1'b1;
          state_d     = retire_state;
          wait_d      = '0;
          stop_pend_d = 1'b0;
        end
      end
      S_MEM: begin
        // wait_q is still zero only in the first MEM cycle.
        if ((wait_q == '0) && inv_mem_addr) begin
          state_d = S_HALT;
          err_d   = 3'd3;
        end else begin
          dmem_req = 1'b1;
          dmem_we  = mem_write;
          if (dmem_ready) begin
            if (mem_write) begin
              pc_write    = 1'b1;
              state_d     = retire_state;
              wait_d      = '0;
              stop_pend_d = 1'b0;
            end else begin
              state_d = S_WB;
            end
          end else if (wait_q == WAIT_LAST) begin
            state_d = S_HALT;
            err_d   = 3'd4;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
      end
      S_WB: begin
        reg_write_en = 1'b1;
        pc_write     = 1'b1;
        state_d      = retire_state;
        wait_d       = '0;
        stop_pend_d  = 1'b0;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      err_q       <= 3'd0;
      wait_q      <= '0;
      stop_pend_q <= 1'b0;
      cycle_q     <= '0;
      instret_q   <= '0;
    end else begin
      state_q     <= state_d;
      err_q       <= err_d;
      wait_q      <= wait_d;
      stop_pend_q <= stop_pend_d;
      if (active && (cycle_q != {CNT_W{1'b1}})) begin
        cycle_q <= cycle_q + CNT_W'(1);
      end
      if (pc_write && (instret_q != {CNT_W{1'b1}})) begin
        instret_q <= instret_q + CNT_W'(1);
      end
    end
  end

  assign state       = state_q;
  assign halted      = (state_q == S_HALT);
  assign err_code    = err_q;
  assign cycle_count = cycle_q;
  assign instret     = instret_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench: directed scenarios plus random instruction streams compared
// cycle by cycle against an instruction-level reference of the sequencer.
module tb_multicycle_sequencer;
  localparam int CW = 5;
  localparam int TO = 15;
  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3;
  localparam logic [2:0] S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6;

  logic clock = 1'b0;
  logic reset, start, stop, mem_read, mem_write, reg_write, branch;
  logic inv_addr, inv_op, inv_func, inv_reg_addr, inv_mem_addr, imem_ready, dmem_ready;
  logic imem_req, dmem_req, dmem_we, ir_write, pc_write, reg_write_en, halted;
  logic [2:0] state, err_code;
  logic [CW-1:0] cycle_count, instret;

  int n_checks = 0;
  int n_fail = 0;
  int exp_cyc = 0;
  int exp_ret = 0;
  logic [2:0] exp_err = 3'd0;

  always #5 clock = ~clock;

  multicycle_sequencer #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write), .branch(branch),
    .inv_addr(inv_addr), .inv_op(inv_op), .inv_func(inv_func), .inv_reg_addr(inv_reg_addr),
    .inv_mem_addr(inv_mem_addr), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write_en(reg_write_en), .state(state), .halted(halted),
    .err_code(err_code), .cycle_count(cycle_count), .instret(instret)
  );

  function automatic logic [CW-1:0] sat(input int v);
    if (v >= (1 << CW) - 1) return {CW{1'b1}};
    return CW'(v);
  endfunction

  // One clock cycle: inputs are already driven; compare outputs at the negedge.
  task automatic cyc(input logic [2:0] st, input logic im, input logic dm, input logic we,
                     input logic ir, input logic pc, input logic rw);
    logic [12:0] exp_v, obs_v;
    logic [2*CW-1:0] exp_c, obs_c;
    @(negedge clock);
    exp_v = {st, im, dm, we, ir, pc, rw, (st == S_HALT), exp_err};
    obs_v = {state, imem_req, dmem_req, dmem_we, ir_write, pc_write, reg_write_en, halted, err_code};
    exp_c = {sat(exp_cyc), sat(exp_ret)};
    obs_c = {cycle_count, instret};
    n_checks++;
    assert (obs_v === exp_v) else begin
      n_fail++;
      $error("FAIL ctl @%0t observed=%b expected=%b", $time, obs_v, exp_v);
    end
    n_checks++;
    assert (obs_c === exp_c) else begin
      n_fail++;
      $error("FAIL counters @%0t observed=%h expected=%h", $time, obs_c, exp_c);
    end
    $display("cycle @%0t state=%0d pc_write=%b cycles=%0d instret=%0d", $time, state, pc_write,
             cycle_count, instret);
    if (st != S_IDLE && st != S_HALT) exp_cyc++;
    if (pc) exp_ret++;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_cnt(input string tag, input logic [2:0] st, input int c, input int r);
    logic [2*CW+2:0] obs_v, exp_v;
    obs_v = {state, cycle_count, instret};
    exp_v = {st, CW'(c), CW'(r)};
    n_checks++;
    assert (obs_v === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs_v, exp_v);
    end
  endtask

  task automatic clear_inputs();
    {start, stop, mem_read, mem_write, reg_write, branch} = '0;
    {inv_addr, inv_op, inv_func, inv_reg_addr, inv_mem_addr, imem_ready, dmem_ready} = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    exp_cyc = 0;
    exp_ret = 0;
    exp_err = 3'd0;
    cyc(S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc(S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    start = 1'b0;
  endtask

  task automatic halt_check(input int n);
    for (int i = 0; i < n; i++) begin
      start = 1'($urandom);
      stop = 1'($urandom);
      imem_ready = 1'($urandom);
      dmem_ready = 1'($urandom);
      cyc(S_HALT, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    {start, stop, imem_ready, dmem_ready} = '0;
  endtask

  // kind: 0 R-type, 1 load, 2 store, 3 branch. err: 0 none, 1 fetch addr, 2 decode,
  // 3 data addr, 4 data timeout, 5 fetch timeout. stop_when: 0 never, 1 early, 2 at retire.
  task automatic run_instr(input int kind, input int fd, input int md, input int err,
                           input int stop_when, input bit noise);
    int sel;
    mem_read = (kind == 1);
    mem_write = (kind == 2);
    reg_write = (kind == 0);
    branch = (kind == 3);
    if (err == 5) begin
      for (int i = 0; i < TO; i++) cyc(S_FETCH, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      exp_err = 3'd4;
      return;
    end
    for (int i = 0; i <= fd; i++) begin
      imem_ready = (i == fd);
      inv_addr = (i == fd) ? (err == 1) : (noise ? 1'($urandom) : 1'b0);
      start = noise ? 1'($urandom) : 1'b0;
      stop = (stop_when == 1) && (i == 0);
      cyc(S_FETCH, 1'b1, 1'b0, 1'b0, (i == fd) && (err != 1), 1'b0, 1'b0);
    end
    {stop, start, imem_ready, inv_addr} = '0;
    if (err == 1) begin
      exp_err = 3'd1;
      return;
    end
    if (err == 2) begin
      sel = noise ? int'($urandom_range(2)) : 0;
      inv_op = (sel == 0);
      inv_func = (sel == 1);
      inv_reg_addr = (sel == 2);
    end
    cyc(S_DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    {inv_op, inv_func, inv_reg_addr} = '0;
    if (err == 2) begin
      exp_err = 3'd2;
      return;
    end
    if (kind == 3) begin
      stop = (stop_when == 2);
      cyc(S_EXEC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      stop = 1'b0;
      return;
    end
    cyc(S_EXEC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    if (kind == 1 || kind == 2) begin
      if (err == 3) begin
        inv_mem_addr = 1'b1;
        cyc(S_MEM, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        inv_mem_addr = 1'b0;
        exp_err = 3'd3;
        return;
      end
      if (err == 4) begin
        for (int i = 0; i < TO; i++) cyc(S_MEM, 1'b0, 1'b1, (kind == 2), 1'b0, 1'b0, 1'b0);
        exp_err = 3'd4;
        return;
      end
      for (int i = 0; i <= md; i++) begin
        dmem_ready = (i == md);
        inv_mem_addr = (i > 0 && noise) ? 1'($urandom) : 1'b0;
        stop = (i == md) && (kind == 2) && (stop_when == 2);
        cyc(S_MEM, 1'b0, 1'b1, (kind == 2), 1'b0, (kind == 2) && (i == md), 1'b0);
      end
      {dmem_ready, inv_mem_addr, stop} = '0;
      if (kind == 2) return;
    end
    stop = (stop_when == 2);
    cyc(S_WB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    stop = 1'b0;
  endtask

  initial begin
    int k, sw, e;
    do_reset();
    chk_cnt("reset_state", S_IDLE, 0, 0);

    // R-type, immediate readies, stop at retire.
    do_start();
    run_instr(0, 0, 0, 0, 2, 1'b0);
    chk_cnt("rtype_counts", S_IDLE, 4, 1);

    // Load with dmem_ready three cycles late.
    do_start();
    run_instr(1, 0, 3, 0, 2, 1'b0);
    chk_cnt("load_counts", S_IDLE, 12, 2);

    // Store then branch back-to-back; stop during the branch's EXECUTE.
    do_start();
    run_instr(2, 1, 1, 0, 0, 1'b0);
    run_instr(3, 0, 0, 0, 2, 1'b0);
    chk_cnt("store_branch_counts", S_IDLE, 21, 4);

    // Stop raised early is held until the retire.
    do_start();
    run_instr(0, 2, 0, 0, 1, 1'b0);
    chk_cnt("pending_stop", S_IDLE, 27, 5);

    // Random instruction stream; counters saturate at the narrow width.
    do_start();
    for (int n = 0; n < 40; n++) begin
      k = int'($urandom_range(3));
      sw = ($urandom_range(7) == 0) ? int'($urandom_range(1, 2)) : 0;
      run_instr(k, int'($urandom_range(3)), int'($urandom_range(4)), 0, sw, 1'b1);
      if (sw != 0) begin
        cyc(S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_start();
      end
    end
    e = int'($urandom_range(1, 5));
    k = (e == 3 || e == 4) ? int'($urandom_range(1, 2)) : int'($urandom_range(3));
    run_instr(k, int'($urandom_range(3)), 0, e, 0, 1'b1);
    halt_check(3);

    // Decode error, data timeout, and other error halts from fresh resets.
    do_reset();
    do_start();
    run_instr(0, 0, 0, 2, 0, 1'b0);
    halt_check(3);
    do_reset();
    do_start();
    run_instr(1, 0, 0, 4, 0, 1'b0);
    halt_check(4);
    do_reset();
    do_start();
    run_instr(0, 1, 0, 1, 0, 1'b0);
    halt_check(2);
    do_reset();
    do_start();
    run_instr(2, 0, 0, 3, 1, 1'b0);
    halt_check(2);
    do_reset();
    do_start();
    run_instr(3, 0, 0, 5, 0, 1'b0);
    halt_check(2);

    // Reset while a load waits in MEM.
    do_reset();
    do_start();
    mem_read = 1'b1;
    imem_ready = 1'b1;
    cyc(S_FETCH, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    imem_ready = 1'b0;
    cyc(S_DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(S_EXEC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(S_MEM, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    cyc(S_MEM, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    exp_cyc = 0;
    exp_ret = 0;
    exp_err = 3'd0;
    chk_cnt("reset_mid_mem", S_IDLE, 0, 0);
    cyc(S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
